adc_multichan_sampler: RTL and testbench
========================================

// Module: adc_multichan_sampler
// PURPOSE
//   Parametrised successor to the single-shot ADC channel decoder. Sequences HOLD requests to
//   spi_ad7324, captures each 16-bit frame, checks the channel ID, converts the 13-bit
//   two's-complement result to offset binary and truncates it to M bits. Optionally averages
//   2^AVG_LOG2 samples per channel, then presents one result register per channel.
//   Sits between spi_ad7324 and the compensator/LCD_display path.
// PARAMETERS
//   NCH       4  channels sampled, 1..4 (ADC ID field is 2 bits)
//   M         12 result width, 1..13 (MSBs of the offset-binary value are kept)
//   AVG_LOG2  0  log2 of samples averaged per channel, 0..4 (0 = no averaging)
//   AUTO      1  1: one START sweeps channels 0..NCH-1; 0: one START samples one channel
//   TIMEOUT   64 CLK20M cycles allowed from HOLD to DONE before abort, >=2
// PORTS
//   CLK20M    in   1        system clock; all logic on rising edge
//   RSTn      in   1        synchronous reset, active low
//   START     in   1        measurement request (MEAS_SWITCH_PULSE); sampled only in IDLE
//   HOLD      out  1        one-cycle conversion request to spi_ad7324
//   DONE      in   1        one-cycle strobe from SPI side: DATA_READ valid this cycle
//   DATA_READ in   16       frame: [14:13] channel ID, [12:0] two's-complement result
//   CH_DATA   out  NCH*M    channel k result at [k*M +: M], offset binary
//   CH_VALID  out  NCH      bit k pulses 1 cycle when CH_DATA[k] updates
//   BUSY      out  1        high in every state except IDLE
//   ERR_CHID  out  1        sticky: received ID != expected channel
//   ERR_TO    out  1        sticky: DONE not seen within TIMEOUT
//   ERR_CLR   in   1        clears ERR_CHID/ERR_TO (a same-cycle new error wins)
// BEHAVIOUR
//   Reset (RSTn=0 at an edge): state IDLE, HOLD=0, CH_DATA=0, CH_VALID=0, BUSY=0, ERR_*=0,
//     expected channel=0, all accumulators and sample counters=0. Reset mid-frame aborts the
//     frame silently; a DONE arriving during reset is ignored.
//   FSM: IDLE -START-> REQ (HOLD=1 for exactly one cycle) -> WAIT.
//     WAIT -DONE-> CAPT; WAIT -(TIMEOUT cycles with no DONE)-> IDLE, ERR_TO=1, expected ch
//     unchanged. The timeout counter clears on entry to WAIT.
//     CAPT -> REQ if AUTO=1 and the captured channel != NCH-1, otherwise -> IDLE.
//   START outside IDLE is ignored (not queued). DONE outside WAIT is ignored.
//   Conversion in CAPT: ob = DATA_READ[12:0] ^ 13'h1000 (adds 2^12); sample = ob[12 -: M].
//     Examples: -4096 -> 0; 0 -> 0x800 (M=12); +4095 -> 0xFFF (M=12, LSB dropped).
//   Channel check: if ID != expected, set ERR_CHID and discard the sample (no accumulate,
//     no CH_VALID). Then set expected=(ID+1) mod NCH to realign. An ID >= NCH is also
//     discarded, and expected is reset to 0.
//     On a match, expected=(expected+1) mod NCH.
//   Averaging: per-channel accumulator of width M+AVG_LOG2 and a sample counter. When the
//     2^AVG_LOG2-th sample is added: CH_DATA[k]=(acc+sample)>>AVG_LOG2 (truncating),
//     CH_VALID[k]=1 for the following cycle, acc and count cleared. AVG_LOG2=0: every sample
//     is written directly. The accumulator cannot overflow by construction.
//   Latency: DONE at cycle t -> CH_DATA/CH_VALID updated at t+2 (CAPT at t+1, register at t+2).
//   AUTO sweep, no averaging: NCH HOLD pulses. Each follows the previous DONE by 2 cycles.
//   CH_DATA holds its value between updates; CH_VALID is never high for 2 consecutive cycles
//     on the same bit.
// TESTING
//   T1 reset: hold RSTn=0 4 cycles while DONE toggles -> all outputs 0, state IDLE, no HOLD.
//   T2 AUTO=1,NCH=4,M=12: START. Answer each HOLD with IDs 0..3, data 13'h1000,13'h0000,
//      13'h0FFF,13'h1FFF -> CH_DATA = 0x000,0x800,0xFFF,0x7FF; 4 HOLD pulses; CH_VALID[k]
//      high 2 cycles after each DONE.
//   T3 ID mismatch: expected 1, frame ID 2 -> ERR_CHID=1, no CH_VALID; next expected 3.
//      ERR_CLR -> ERR_CHID=0.
//   T4 timeout TIMEOUT=64: START, never DONE -> ERR_TO=1 exactly 64 cycles after WAIT entry;
//      BUSY=0 the next cycle; a later START retries the same channel.
//   T5 AVG_LOG2=2,AUTO=0,NCH=1: four frames, offset values 0x100,0x101,0x102,0x104 ->
//      one CH_VALID, CH_DATA=0x101; no CH_VALID after frames 1-3.
//   T6 START while BUSY, plus RSTn=0 during WAIT -> START ignored; after reset HOLD stays 0
//      and the late DONE is discarded.

Source files
------------

// File: rtl/adc_multichan_sampler.sv
// Sequences AD7324 conversions, checks channel IDs, converts results to offset binary and
// optionally averages 2^AVG_LOG2 samples into one result register per channel.
module adc_multichan_sampler #(
  parameter int NCH      = 4,
  parameter int M        = 12,
  parameter int AVG_LOG2 = 0,
  parameter int AUTO     = 1,
  parameter int TIMEOUT  = 64
) (
  input  logic             CLK20M,
  input  logic             RSTn,
  input  logic             START,
  output logic             HOLD,
  input  logic             DONE,
  input  logic [15:0]      DATA_READ,
  output logic [NCH*M-1:0] CH_DATA,
  output logic [NCH-1:0]   CH_VALID,
  output logic             BUSY,
  output logic             ERR_CHID,
  output logic             ERR_TO,
  input  logic             ERR_CLR
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int AW = M + AVG_LOG2;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [2:0]    NCH_W    = 3'(NCH);
  localparam logic [1:0]    LAST_ID  = 2'(NCH - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_CAPT} state_t;

  state_t           r_state;
  logic             r_hold;
  logic             r_err_chid;
  logic             r_err_to;
  logic [15:0]      r_frame;
  logic [1:0]       r_exp;
  logic [TW-1:0]    r_to;
  logic [NCH*M-1:0] r_ch_data;
  logic [NCH-1:0]   r_ch_valid;
  logic [AW-1:0]    r_acc [NCH];
  logic [CW-1:0]    r_cnt [NCH];

  logic [1:0]    w_id;
  logic [12:0]   w_ob;
  logic [M-1:0]  w_sample;
  logic          w_id_ok;
  logic [IW-1:0] w_ch;
  logic [1:0]    w_next_exp;
  logic [AW-1:0] w_sum;
  logic          w_unused;

  // Flipping the sign bit of the 13-bit two's-complement value yields offset binary
  assign w_id       = r_frame[14:13];
  assign w_ob       = r_frame[12:0] ^ 13'h1000;
  assign w_sample   = w_ob[12 -: M];
  assign w_id_ok    = {1'b0, w_id} < NCH_W;
  assign w_ch       = w_id[IW-1:0];
  assign w_next_exp = (w_id == LAST_ID) ? 2'd0 : w_id + 2'd1;
  assign w_sum      = r_acc[w_ch] + AW'(w_sample);
  assign w_unused   = ^{r_frame[15], w_ob};

  always_ff @(posedge CLK20M) begin
    if (!RSTn) begin
      r_state    <= S_IDLE;
      r_hold     <= 1'b0;
      r_err_chid <= 1'b0;
      r_err_to   <= 1'b0;
      r_frame    <= '0;
      r_exp      <= '0;
      r_to       <= '0;
      r_ch_data  <= '0;
      r_ch_valid <= '0;
      for (int k = 0; k < NCH; k++) begin
        r_acc[k] <= '0;
        r_cnt[k] <= '0;
      end
    end else begin
      r_hold     <= 1'b0;
      r_ch_valid <= '0;
      if (ERR_CLR) begin
        r_err_chid <= 1'b0;
        r_err_to   <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_state <= S_REQ;
            r_hold  <= 1'b1;
          end
        end
        S_REQ: begin
          r_state <= S_WAIT;
          r_to    <= '0;
        end
        S_WAIT: begin
          if (DONE) begin
            r_frame <= DATA_READ;
            r_state <= S_CAPT;
          end else if (r_to == TO_LAST) begin
            r_state  <= S_IDLE;
            r_err_to <= 1'b1;
          end else begin
            r_to <= r_to + TW'(1);
          end
        end
        S_CAPT: begin
          // Error updates come after the ERR_CLR clear so a same-cycle new error wins
          if (!w_id_ok) begin
            r_err_chid <= 1'b1;
            r_exp      <= 2'd0;
          end else if (w_id != r_exp) begin
            r_err_chid <= 1'b1;
            r_exp      <= w_next_exp;
          end else begin
            r_exp <= w_next_exp;
            if (r_cnt[w_ch] == CNT_LAST) begin
              r_ch_data[w_ch*M +: M] <= w_sum[AVG_LOG2 +: M];
              r_ch_valid[w_ch]       <= 1'b1;
              r_acc[w_ch]            <= '0;
              r_cnt[w_ch]            <= '0;
            end else begin
              r_acc[w_ch] <= w_sum;
              r_cnt[w_ch] <= r_cnt[w_ch] + CW'(1);
            end
          end
          if (AUTO != 0 && w_id != LAST_ID) begin
            r_state <= S_REQ;
            r_hold  <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign HOLD     = r_hold;
  assign BUSY     = (r_state != S_IDLE);
  assign CH_DATA  = r_ch_data;
  assign CH_VALID = r_ch_valid;
  assign ERR_CHID = r_err_chid;
  assign ERR_TO   = r_err_to;

endmodule

// File: tb/tb_adc_multichan_sampler.sv
// Bench for a sweeping 4-channel sampler and a 1-channel averaging sampler, both checked
// against a frame-level model of conversion, channel tracking and averaging.
module tb_adc_multichan_sampler;
  localparam int NCH = 4;
  localparam int M   = 12;

  logic CLK20M = 1'b0;
  logic RSTn;
  logic start, done, errClr, hold, busy, errChid, errTo;
  logic [15:0] dataRead;
  logic [NCH*M-1:0] chData;
  logic [NCH-1:0] chValid;

  logic avgStart, avgDone, avgErrClr, avgHold, avgBusy, avgErrChid, avgErrTo;
  logic [15:0] avgDataRead;
  logic [M-1:0] avgChData;
  logic [0:0] avgChValid;

  int vectors = 0;
  int miscompares = 0;
  int holdCount = 0;

  logic [M-1:0] modelData [NCH];
  int modelExp;
  logic modelErr;

  typedef struct { logic [1:0] id; logic [12:0] raw; logic [M-1:0] expData; } sweepVec_t;
  typedef struct { logic [M-1:0] value; logic expValid; logic [M-1:0] expData; } avgVec_t;
  sweepVec_t sweepTab[4];
  avgVec_t avgTab[4];

  always #25 CLK20M = ~CLK20M;

  adc_multichan_sampler #(.NCH(NCH), .M(M), .AVG_LOG2(0), .AUTO(1), .TIMEOUT(64)) dut (
    .CLK20M(CLK20M), .RSTn(RSTn), .START(start), .HOLD(hold), .DONE(done),
    .DATA_READ(dataRead), .CH_DATA(chData), .CH_VALID(chValid), .BUSY(busy),
    .ERR_CHID(errChid), .ERR_TO(errTo), .ERR_CLR(errClr)
  );

  adc_multichan_sampler #(.NCH(1), .M(M), .AVG_LOG2(2), .AUTO(0), .TIMEOUT(64)) dutAvg (
    .CLK20M(CLK20M), .RSTn(RSTn), .START(avgStart), .HOLD(avgHold), .DONE(avgDone),
    .DATA_READ(avgDataRead), .CH_DATA(avgChData), .CH_VALID(avgChValid), .BUSY(avgBusy),
    .ERR_CHID(avgErrChid), .ERR_TO(avgErrTo), .ERR_CLR(avgErrClr)
  );

  always @(negedge CLK20M) if (hold === 1'b1) holdCount <= holdCount + 1;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete, got hang, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Signed 13-bit reading shifted up by 2^12, keeping the top M of 13 bits
  function automatic logic [M-1:0] toSample(input logic [12:0] raw);
    int v;
    v = raw[12] ? int'(raw) - 8192 : int'(raw);
    v = v + 4096;
    return M'(v >> (13 - M));
  endfunction

  function automatic logic [NCH*M-1:0] packModel();
    logic [NCH*M-1:0] p;
    for (int k = 0; k < NCH; k++) p[k*M +: M] = modelData[k];
    return p;
  endfunction

  task automatic pulseStart();
    start = 1'b1;
    @(negedge CLK20M);
    start = 1'b0;
  endtask

  task automatic pulseErrClr();
    errClr = 1'b1;
    @(negedge CLK20M);
    errClr = 1'b0;
    modelErr = 1'b0;
  endtask

  task automatic waitHold(input string tag, input int budget);
    int n = 0;
    while (hold !== 1'b1 && n < budget) begin
      @(negedge CLK20M);
      n++;
    end
    checkOutput({tag, " holdSeen"}, hold, 1'b1);
    @(negedge CLK20M);
  endtask

  task automatic applyStimulus(input logic [1:0] id, input logic [12:0] raw, input logic clrInCapt);
    done = 1'b1;
    dataRead = {1'b0, id, raw};
    @(negedge CLK20M);
    done = 1'b0;
    dataRead = 16'($urandom);
    errClr = clrInCapt;
    @(negedge CLK20M);
    errClr = 1'b0;
  endtask

  task automatic doFrame(input logic [1:0] id, input logic [12:0] raw, input logic clr, input string tag);
    logic [NCH-1:0] expValid;
    applyStimulus(id, raw, clr);
    if (clr) modelErr = 1'b0;
    expValid = '0;
    if (int'(id) != modelExp) begin
      modelErr = 1'b1;
    end else begin
      modelData[id] = toSample(raw);
      expValid[id] = 1'b1;
    end
    modelExp = (int'(id) + 1) % NCH;
    checkOutput({tag, " valid"}, chValid, expValid);
    checkOutput({tag, " data"}, chData, packModel());
    checkOutput({tag, " errChid"}, errChid, modelErr);
    checkOutput({tag, " holdNext"}, hold, id != 2'(NCH - 1));
  endtask

  task automatic avgStimulus(input logic [M-1:0] value);
    int n = 0;
    avgStart = 1'b1;
    @(negedge CLK20M);
    avgStart = 1'b0;
    while (avgHold !== 1'b1 && n < 4) begin
      @(negedge CLK20M);
      n++;
    end
    checkOutput("avg holdSeen", avgHold, 1'b1);
    @(negedge CLK20M);
    avgDone = 1'b1;
    avgDataRead = {1'b0, 2'd0, {value, 1'($urandom)} ^ 13'h1000};
    @(negedge CLK20M);
    avgDone = 1'b0;
    @(negedge CLK20M);
  endtask

  initial begin
    logic [1:0] id;
    logic [12:0] raw;
    logic [M-1:0] val;
    int toCycle, holdBase, sum;
    logic busyBefore;

    sweepTab[0] = '{2'd0, 13'h1000, 12'h000};
    sweepTab[1] = '{2'd1, 13'h0000, 12'h800};
    sweepTab[2] = '{2'd2, 13'h0FFF, 12'hFFF};
    sweepTab[3] = '{2'd3, 13'h1FFF, 12'h7FF};
    avgTab[0] = '{12'h100, 1'b0, 12'h000};
    avgTab[1] = '{12'h101, 1'b0, 12'h000};
    avgTab[2] = '{12'h102, 1'b0, 12'h000};
    avgTab[3] = '{12'h104, 1'b1, 12'h101};

    RSTn = 1'b0; start = 1'b0; done = 1'b0; errClr = 1'b0; dataRead = '0;
    avgStart = 1'b0; avgDone = 1'b0; avgErrClr = 1'b0; avgDataRead = '0;

    // T1: reset held while DONE toggles
    for (int c = 0; c < 4; c++) begin
      done = c[0];
      avgDone = c[0];
      dataRead = 16'($urandom);
      avgDataRead = 16'($urandom);
      @(negedge CLK20M);
      checkOutput("T1 hold", hold, 1'b0);
    end
    checkOutput("T1 busy", busy, 1'b0);
    checkOutput("T1 chData", chData, '0);
    checkOutput("T1 chValid", chValid, '0);
    checkOutput("T1 errs", {errChid, errTo}, 2'b00);
    checkOutput("T1 avg", {avgHold, avgBusy, avgChData, avgChValid}, '0);
    done = 1'b0; avgDone = 1'b0;
    RSTn = 1'b1;
    for (int k = 0; k < NCH; k++) modelData[k] = '0;
    modelExp = 0;
    modelErr = 1'b0;
    @(negedge CLK20M);

    // T2: table-driven sweep
    holdBase = holdCount;
    pulseStart();
    for (int i = 0; i < 4; i++) begin
      waitHold("T2", 4);
      checkOutput("T2 validCleared", chValid, '0);
      doFrame(sweepTab[i].id, sweepTab[i].raw, 1'b0, "T2");
      checkOutput("T2 table", chData[i*M +: M], sweepTab[i].expData);
    end
    checkOutput("T2 busyAfter", busy, 1'b0);
    @(negedge CLK20M);
    checkOutput("T2 validPulse", chValid, '0);
    checkOutput("T2 holdCount", holdCount - holdBase, 4);

    // Randomised sweeps with occasional wrong IDs
    for (int s = 0; s < 6; s++) begin
      pulseErrClr();
      checkOutput("rand errClr", errChid, 1'b0);
      pulseStart();
      for (int f = 0; f < 10; f++) begin
        waitHold("rand", 4);
        repeat ($urandom_range(0, 4)) @(negedge CLK20M);
        if (f == 9) id = 2'd3;
        else if ($urandom_range(0, 5) == 0) id = 2'($urandom_range(0, 3));
        else id = 2'(modelExp);
        raw = 13'($urandom);
        doFrame(id, raw, 1'b0, "rand");
        if (id == 2'd3) break;
      end
      @(negedge CLK20M);
    end

    // T3: ID mismatch, clear in the same cycle as the new error
    pulseErrClr();
    pulseStart();
    waitHold("T3", 4);
    doFrame(2'd0, 13'h0123, 1'b0, "T3 ch0");
    waitHold("T3", 4);
    doFrame(2'd2, 13'h0456, 1'b1, "T3 mismatch");
    checkOutput("T3 errSet", errChid, 1'b1);
    waitHold("T3", 4);
    doFrame(2'd3, 13'h0789, 1'b0, "T3 realigned");
    checkOutput("T3 realignValid", chValid, 4'b1000);
    @(negedge CLK20M);
    pulseErrClr();
    checkOutput("T3 errCleared", errChid, 1'b0);

    // T4: timeout on channel 1, then retry the same channel
    pulseStart();
    waitHold("T4", 4);
    doFrame(2'd0, 13'($urandom), 1'b0, "T4 ch0");
    @(negedge CLK20M);
    toCycle = 0;
    busyBefore = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      busyBefore = busy;
      @(negedge CLK20M);
      if (errTo === 1'b1) begin
        toCycle = k;
        break;
      end
    end
    checkOutput("T4 timeoutCycle", toCycle, 64);
    checkOutput("T4 busyBefore", busyBefore, 1'b1);
    checkOutput("T4 busyAfter", busy, 1'b0);
    pulseStart();
    waitHold("T4 retry", 4);
    doFrame(2'd1, 13'($urandom), 1'b0, "T4 retry");
    waitHold("T4", 4);
    doFrame(2'd2, 13'($urandom), 1'b0, "T4 ch2");
    waitHold("T4", 4);
    doFrame(2'd3, 13'($urandom), 1'b0, "T4 ch3");
    checkOutput("T4 errToSticky", errTo, 1'b1);
    pulseErrClr();
    checkOutput("T4 errToCleared", errTo, 1'b0);

    // T5: averaging instance, fixed table then random groups of four
    for (int i = 0; i < 4; i++) begin
      avgStimulus(avgTab[i].value);
      checkOutput("T5 valid", avgChValid, avgTab[i].expValid);
      checkOutput("T5 data", avgChData, avgTab[i].expData);
    end
    @(negedge CLK20M);
    checkOutput("T5 validPulse", avgChValid, 1'b0);
    for (int g = 0; g < 3; g++) begin
      sum = 0;
      for (int i = 0; i < 4; i++) begin
        val = M'($urandom);
        sum += int'(val);
        avgStimulus(val);
        checkOutput("avg valid", avgChValid, i == 3);
        if (i == 3) checkOutput("avg data", avgChData, sum / 4);
      end
    end
    checkOutput("T5 errs", {avgErrChid, avgErrTo, avgBusy}, 3'b000);

    // T6: START while busy is ignored, reset during WAIT with a late DONE
    holdBase = holdCount;
    pulseStart();
    start = 1'b1;
    @(negedge CLK20M);
    @(negedge CLK20M);
    checkOutput("T6 busyInWait", busy, 1'b1);
    RSTn = 1'b0;
    done = 1'b1;
    dataRead = {1'b0, 2'd0, 13'h0AAA};
    @(negedge CLK20M);
    @(negedge CLK20M);
    RSTn = 1'b1;
    start = 1'b0;
    @(negedge CLK20M);
    done = 1'b0;
    repeat (4) @(negedge CLK20M);
    for (int k = 0; k < NCH; k++) modelData[k] = '0;
    modelExp = 0;
    modelErr = 1'b0;
    checkOutput("T6 holdCount", holdCount - holdBase, 1);
    checkOutput("T6 busy", busy, 1'b0);
    checkOutput("T6 chData", chData, '0);
    checkOutput("T6 chValid", chValid, '0);
    checkOutput("T6 errs", {errChid, errTo}, 2'b00);

    pulseStart();
    for (int i = 0; i < 4; i++) begin
      waitHold("T6 sweep", 4);
      doFrame(2'(i), 13'($urandom), 1'b0, "T6 sweep");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
